swap_restore_fifo: RTL and testbench
====================================

Name: swap_restore_fifo

Overview:
- Decoder side of the compare-and-swap stage in the BFP16 add / sort datapath.
- Upstream emits ordered pairs (max, min) plus the comparison flag, where flag = 1 means a < b at the comparator.
- This block buffers those pairs in a small FIFO and restores the original (a, b) operand order on the output, using valid/ready handshakes on both sides.
- It also keeps a saturating count of delivered pairs that had been swapped.

Parameters:
- SIZE_DATA, 8: width of each data word.
- DEPTH, 4: FIFO entries; power of two, 2 or more.
- CNT_W, 16: width of the swap counter.

Ports:
- i_clk  in  1  clock; all logic is on the rising edge.
- i_rst_n  in  1  reset; synchronous, active-low.
- i_valid  in  1  upstream pair valid.
- o_ready  out  1  block can accept a pair.
- i_comp_less  in  1  swap flag (1 = original a < b, so a was routed to min).
- i_data_max  in  SIZE_DATA  larger operand.
- i_data_min  in  SIZE_DATA  smaller operand.
- o_valid  out  1  restored pair available.
- i_ready  in  1  downstream accepts.
- o_data_a  out  SIZE_DATA  restored operand a.
- o_data_b  out  SIZE_DATA  restored operand b.
- o_count  out  $clog2(DEPTH+1)  current occupancy.
- i_clr_cnt  in  1  synchronous clear of the swap counter.
- o_swap_cnt  out  CNT_W  delivered pairs with flag = 1.

Behaviour:
- Reset (i_rst_n = 0 at a clock edge):
  - Pointers and occupancy go to 0; o_swap_cnt goes to 0.
  - While reset is low, all inputs are ignored.
  - Storage RAM is not reset.
- Outputs during and after reset:
  - o_valid = 0, o_count = 0, o_ready = 1, o_data_a = o_data_b = 0.
- Push: i_valid && o_ready. The entry {i_comp_less, i_data_max, i_data_min} is written at the write pointer, which then increments.
- Pop: o_valid && i_ready. The read pointer increments.
- Pointers are log2(DEPTH) bits and wrap naturally from DEPTH-1 to 0. Occupancy is tracked by a separate counter.
- o_ready = (o_count != DEPTH). It is derived from registered state only, with no combinational path from i_ready.
- o_valid = (o_count != 0).
- Latency: a pair pushed at edge N is visible with o_valid = 1 after edge N. There is no same-cycle input-to-output bypass.
- Simultaneous push and pop, not full and not empty: occupancy is unchanged and both pointers advance.
- When full: o_ready = 0, so no push is possible even if a pop occurs that cycle. o_ready rises in the cycle after the pop.
- When empty: no pop; i_ready is don't-care.
- Restore rule, applied to the head entry:
  - flag = 1: o_data_a = min, o_data_b = max.
  - flag = 0: o_data_a = max, o_data_b = min.
- When o_valid = 0, o_data_a and o_data_b are forced to 0.
- Output stability: while o_valid && !i_ready, o_data_a and o_data_b hold the same value.
- Swap counter:
  - Increments on each pop whose head flag = 1.
  - Saturates at 2^CNT_W - 1.
  - i_clr_cnt has priority: clear together with a qualifying pop gives 0.
- Reset mid-stream: all buffered pairs are discarded. The first pair accepted after reset goes to entry 0.

Decomposition:
- Shared package (sort_pkg) holds:
  - a packed typedef swap_entry_t: {logic swapped; logic [SIZE_DATA-1:0] max; logic [SIZE_DATA-1:0] min}.
  - a function restore_pair(entry) that returns {a, b}. The comparator-side testbench reuses it as the reference model.
- One natural sub-module, swap_restore_fifo_mem: a DEPTH x entry-width register array with one write port and one asynchronous read port.
- Control logic, the restore mux and the counter stay in the top module.

Test Plan:
- Reset then idle:
  - Required: o_valid = 0, o_ready = 1, o_count = 0, o_data_a = o_data_b = 0, o_swap_cnt = 0.
- Single pass-through:
  - Stimulus: push max=0x9C, min=0x12, flag=1 at edge 1; i_ready = 1.
  - Required: after edge 1, o_valid = 1, a = 0x12, b = 0x9C. After edge 2, o_valid = 0 and o_swap_cnt = 1.
- Fill and backpressure, DEPTH = 4:
  - Stimulus: push 4 pairs with i_ready = 0.
  - Required: o_ready = 0 and o_count = 4. A 5th i_valid is not accepted. Pop one; o_ready = 1 on the next cycle.
- Wrap-around with simultaneous push and pop:
  - Stimulus: 10 pairs with alternating flags, pushed and popped in the same cycles, with o_count held at 2.
  - Required: outputs match restore_pair in order, and o_swap_cnt = 5.
- Stall stability:
  - Stimulus: o_valid = 1 with i_ready held 0 for 3 cycles.
  - Required: a and b are unchanged throughout; pop on the 4th cycle.
- Reset mid-operation and counter clear:
  - Stimulus: with 3 entries buffered, assert i_rst_n = 0 for one edge. Separately, assert i_clr_cnt together with a flag=1 pop.
  - Required: after the reset, o_count = 0 and o_valid = 0. After the clear-plus-pop, o_swap_cnt = 0.
  - Saturation: preset CNT_W = 2, then 5 swapped pops; o_swap_cnt stops at 3.

Source files
------------

// File: rtl/sort_pkg.sv
// Shared types for the BFP16 compare-and-swap stage: stored pair entry and operand-order restore.
// Combinational helpers only; no latency, no flow control.
package sort_pkg;

    localparam int SORT_W = 8;

    typedef struct packed {
        logic              swapped;
        logic [SORT_W-1:0] max;
        logic [SORT_W-1:0] min;
    } swap_entry_t;

    // Returns {a, b}: a swapped pair had a < b, so a sits in min.
    function automatic logic [2*SORT_W-1:0] restore_pair(input swap_entry_t entry);
        return entry.swapped ? {entry.min, entry.max} : {entry.max, entry.min};
    endfunction

endpackage

// File: rtl/swap_restore_fifo_mem.sv
// DEPTH x WIDTH register array, one write port, asynchronous read port.
// Write lands on the rising edge; the read is combinational; no flow control of its own.
module swap_restore_fifo_mem #(
    parameter int WIDTH = 17,
    parameter int DEPTH = 4,
    parameter int AW    = $clog2(DEPTH)
) (
    input  logic             clk,
    input  logic             wr_en,
    input  logic [AW-1:0]    wr_addr,
    input  logic [WIDTH-1:0] wr_data,
    input  logic [AW-1:0]    rd_addr,
    output logic [WIDTH-1:0] rd_data
);

    logic [WIDTH-1:0] mem [DEPTH];

    always_ff @(posedge clk) begin
        if (wr_en) begin
            mem[wr_addr] <= wr_data;
        end
    end

    assign rd_data = mem[rd_addr];

endmodule

// File: rtl/swap_restore_fifo.sv
// Buffers (max, min, swapped) pairs and restores original (a, b) order; counts swapped pairs delivered.
// One-cycle push-to-output latency; o_ready drops only when full and depends on registered state only.
module swap_restore_fifo
    import sort_pkg::*;
#(
    parameter int SIZE_DATA = 8,
    parameter int DEPTH     = 4,
    parameter int CNT_W     = 16
) (
    input  logic                       i_clk,
    input  logic                       i_rst_n,
    input  logic                       i_valid,
    output logic                       o_ready,
    input  logic                       i_comp_less,
    input  logic [SIZE_DATA-1:0]       i_data_max,
    input  logic [SIZE_DATA-1:0]       i_data_min,
    output logic                       o_valid,
    input  logic                       i_ready,
    output logic [SIZE_DATA-1:0]       o_data_a,
    output logic [SIZE_DATA-1:0]       o_data_b,
    output logic [$clog2(DEPTH+1)-1:0] o_count,
    input  logic                       i_clr_cnt,
    output logic [CNT_W-1:0]           o_swap_cnt
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam int OCC_W = $clog2(DEPTH+1);
    localparam int ENT_W = 2*SIZE_DATA + 1;

    logic [PTR_W-1:0] wr_ptr;
    logic [PTR_W-1:0] rd_ptr;
    logic [OCC_W-1:0] occ;
    logic [CNT_W-1:0] swap_cnt;
    logic [ENT_W-1:0] wr_entry;
    logic [ENT_W-1:0] head;
    logic             push;
    logic             pop;
    logic             head_swapped;
    logic [SIZE_DATA-1:0] head_max;
    logic [SIZE_DATA-1:0] head_min;

    assign o_ready = (occ != OCC_W'(DEPTH));
    assign o_valid = (occ != '0);
    assign o_count = occ;
    assign o_swap_cnt = swap_cnt;

    // Inputs are ignored while reset is held, including the RAM write.
    assign push = i_rst_n & i_valid & o_ready;
    assign pop  = i_rst_n & o_valid & i_ready;

    assign wr_entry = {i_comp_less, i_data_max, i_data_min};

    swap_restore_fifo_mem #(
        .WIDTH (ENT_W),
        .DEPTH (DEPTH),
        .AW    (PTR_W)
    ) u_mem (
        .clk     (i_clk),
        .wr_en   (push),
        .wr_addr (wr_ptr),
        .wr_data (wr_entry),
        .rd_addr (rd_ptr),
        .rd_data (head)
    );

    assign head_swapped = head[ENT_W-1];
    assign head_max     = head[2*SIZE_DATA-1:SIZE_DATA];
    assign head_min     = head[SIZE_DATA-1:0];

    always_comb begin
        o_data_a = '0;
        o_data_b = '0;
        if (o_valid) begin
            o_data_a = head_swapped ? head_min : head_max;
            o_data_b = head_swapped ? head_max : head_min;
        end
    end

    always_ff @(posedge i_clk) begin
        if (!i_rst_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            occ    <= '0;
        end else begin
            if (push) begin
                wr_ptr <= wr_ptr + 1'b1;
            end
            if (pop) begin
                rd_ptr <= rd_ptr + 1'b1;
            end
            case ({push, pop})
                2'b10:   occ <= occ + 1'b1;
                2'b01:   occ <= occ - 1'b1;
                default: occ <= occ;
            endcase
        end
    end

    // Clear wins over a qualifying pop in the same cycle.
    always_ff @(posedge i_clk) begin
        if (!i_rst_n) begin
            swap_cnt <= '0;
        end else if (i_clr_cnt) begin
            swap_cnt <= '0;
        end else if (pop && head_swapped && (swap_cnt != {CNT_W{1'b1}})) begin
            swap_cnt <= swap_cnt + 1'b1;
        end
    end

endmodule

// File: tb/tb_swap_restore_fifo.sv
module tb_swap_restore_fifo;
    import sort_pkg::*;

    localparam int DEPTH = 4;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       in_valid;
    logic       comp_less;
    logic [7:0] dmax;
    logic [7:0] dmin;
    logic       dn_ready;
    logic       clr;
    logic       clr2;

    logic        rdy, ovld;
    logic [7:0]  da, db;
    logic [2:0]  count;
    logic [15:0] swap_cnt;

    logic        rdy2, ovld2;
    logic [7:0]  da2, db2;
    logic [2:0]  count2;
    logic [1:0]  swap_cnt2;

    swap_restore_fifo #(.SIZE_DATA(8), .DEPTH(DEPTH), .CNT_W(16)) dut (
        .i_clk(clk), .i_rst_n(rst_n), .i_valid(in_valid), .o_ready(rdy),
        .i_comp_less(comp_less), .i_data_max(dmax), .i_data_min(dmin),
        .o_valid(ovld), .i_ready(dn_ready), .o_data_a(da), .o_data_b(db),
        .o_count(count), .i_clr_cnt(clr), .o_swap_cnt(swap_cnt)
    );

    swap_restore_fifo #(.SIZE_DATA(8), .DEPTH(DEPTH), .CNT_W(2)) dut_sat (
        .i_clk(clk), .i_rst_n(rst_n), .i_valid(in_valid), .o_ready(rdy2),
        .i_comp_less(comp_less), .i_data_max(dmax), .i_data_min(dmin),
        .o_valid(ovld2), .i_ready(dn_ready), .o_data_a(da2), .o_data_b(db2),
        .o_count(count2), .i_clr_cnt(clr2), .o_swap_cnt(swap_cnt2)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [7:0] a;
        logic [7:0] b;
        logic       f;
    } exp_t;

    typedef struct {
        logic       f;
        logic [7:0] mx;
        logic [7:0] mn;
        logic [7:0] exp_a;
        logic [7:0] exp_b;
        int         exp_swap;
    } vec_t;

    exp_t sb[$];
    int   m_occ;
    int   m_swap;
    int   m_swap2;
    int   n_tests;
    int   n_fail;

    task automatic check(input string name, input int act, input int exp);
        n_tests++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    // Checks visible state against the model, then advances one edge and updates the model.
    task automatic cycle();
        bit   push, pop;
        exp_t e;
        logic [15:0] rp;
        check("ready", int'(rdy), int'(m_occ != DEPTH));
        check("valid", int'(ovld), int'(m_occ != 0));
        check("count", int'(count), m_occ);
        check("swap_cnt", int'(swap_cnt), m_swap);
        check("swap_cnt_sat", int'(swap_cnt2), m_swap2);
        if (m_occ != 0) begin
            check("data_a", int'(da), int'(sb[0].a));
            check("data_b", int'(db), int'(sb[0].b));
        end else begin
            check("idle_a", int'(da), 0);
            check("idle_b", int'(db), 0);
        end
        push = rst_n && in_valid && (m_occ != DEPTH);
        pop  = rst_n && dn_ready && (m_occ != 0);
        rp   = restore_pair('{swapped: comp_less, max: dmax, min: dmin});
        @(posedge clk);
        #1;
        if (!rst_n) begin
            sb.delete();
            m_occ = 0; m_swap = 0; m_swap2 = 0;
        end else begin
            if (pop) begin
                e = sb.pop_front();
                if (e.f && m_swap < 65535) m_swap++;
                if (e.f && m_swap2 < 3) m_swap2++;
            end
            if (clr) m_swap = 0;
            if (clr2) m_swap2 = 0;
            if (push) begin
                e.a = rp[15:8]; e.b = rp[7:0]; e.f = comp_less;
                sb.push_back(e);
            end
            m_occ = m_occ + int'(push) - int'(pop);
        end
    endtask

    task automatic drive(input logic f, input logic [7:0] mx, input logic [7:0] mn);
        in_valid = 1'b1; comp_less = f; dmax = mx; dmin = mn;
    endtask

    task automatic drain();
        in_valid = 1'b0; dn_ready = 1'b1;
        for (int k = 0; k < 3*DEPTH && m_occ != 0; k++) cycle();
    endtask

    initial begin
        #200000;
        $display("FAIL timeout: simulation did not finish");
        $fatal(1, "timeout");
    end

    initial begin
        vec_t vecs[5];
        vecs[0] = '{1'b1, 8'h9C, 8'h12, 8'h12, 8'h9C, 1};
        vecs[1] = '{1'b0, 8'h9C, 8'h12, 8'h9C, 8'h12, 1};
        vecs[2] = '{1'b1, 8'hFF, 8'h00, 8'h00, 8'hFF, 2};
        vecs[3] = '{1'b0, 8'h80, 8'h7F, 8'h80, 8'h7F, 2};
        vecs[4] = '{1'b1, 8'h55, 8'h55, 8'h55, 8'h55, 3};

        n_tests = 0; n_fail = 0;
        m_occ = 0; m_swap = 0; m_swap2 = 0;
        rst_n = 1'b0; in_valid = 1'b0; comp_less = 1'b0; dmax = '0; dmin = '0;
        dn_ready = 1'b0; clr = 1'b0; clr2 = 1'b0;

        // Reset then idle; a valid during reset must be ignored.
        @(posedge clk); #1;
        drive(1'b1, 8'hAA, 8'h01);
        cycle();
        in_valid = 1'b0;
        cycle();
        rst_n = 1'b1;
        check("rst_valid", int'(ovld), 0);
        check("rst_ready", int'(rdy), 1);
        check("rst_count", int'(count), 0);
        check("rst_a", int'(da), 0);
        check("rst_b", int'(db), 0);
        check("rst_swap", int'(swap_cnt), 0);
        cycle();

        // Table-driven pass-through with hand-computed restore results.
        for (int i = 0; i < 5; i++) begin
            drive(vecs[i].f, vecs[i].mx, vecs[i].mn);
            dn_ready = 1'b1;
            cycle();
            in_valid = 1'b0;
            check("vec_valid", int'(ovld), 1);
            check("vec_a", int'(da), int'(vecs[i].exp_a));
            check("vec_b", int'(db), int'(vecs[i].exp_b));
            cycle();
            check("vec_empty", int'(ovld), 0);
            check("vec_swap", int'(swap_cnt), vecs[i].exp_swap);
        end

        // Fill under backpressure, refused 5th push, ready returns after a pop.
        dn_ready = 1'b0;
        for (int i = 0; i < DEPTH; i++) begin
            drive(i[0], 8'($urandom_range(128, 255)), 8'($urandom_range(0, 127)));
            cycle();
        end
        check("full_ready", int'(rdy), 0);
        check("full_count", int'(count), DEPTH);
        drive(1'b1, 8'hEE, 8'h11);
        cycle();
        check("full_nopush", int'(count), DEPTH);
        dn_ready = 1'b1;
        cycle();
        check("full_pop_count", int'(count), DEPTH-1);
        check("full_ready_back", int'(rdy), 1);
        drain();

        // Wrap-around: occupancy held at 2 while pushing and popping together.
        clr = 1'b1; in_valid = 1'b0; dn_ready = 1'b0;
        cycle();
        clr = 1'b0;
        for (int i = 0; i < 10; i++) begin
            drive(~i[0], 8'(8'h90 + i), 8'(8'h10 + i));
            dn_ready = (i >= 2);
            cycle();
            if (i >= 2) check("wrap_count", int'(count), 2);
        end
        drain();
        check("wrap_swap", int'(swap_cnt), 5);

        // Stall stability: data held for three cycles of backpressure.
        drive(1'b0, 8'hA5, 8'h3C);
        dn_ready = 1'b0;
        cycle();
        in_valid = 1'b0;
        for (int i = 0; i < 3; i++) begin
            check("stall_a", int'(da), 8'hA5);
            check("stall_b", int'(db), 8'h3C);
            cycle();
        end
        dn_ready = 1'b1;
        cycle();
        check("stall_popped", int'(ovld), 0);

        // Reset mid-operation discards three buffered pairs.
        dn_ready = 1'b0;
        for (int i = 0; i < 3; i++) begin
            drive(1'b1, 8'(8'hC0 + i), 8'(8'h20 + i));
            cycle();
        end
        rst_n = 1'b0; in_valid = 1'b0;
        cycle();
        rst_n = 1'b1;
        check("midrst_count", int'(count), 0);
        check("midrst_valid", int'(ovld), 0);
        drive(1'b0, 8'h77, 8'h44);
        cycle();
        in_valid = 1'b0;
        check("postrst_a", int'(da), 8'h77);
        check("postrst_b", int'(db), 8'h44);
        drain();

        // Clear together with a swapped pop leaves the counter at 0.
        dn_ready = 1'b0;
        drive(1'b1, 8'hF0, 8'h0F); cycle();
        drive(1'b1, 8'hE0, 8'h0E); cycle();
        in_valid = 1'b0; dn_ready = 1'b1;
        cycle();
        check("pre_clr_swap", int'(swap_cnt), 1);
        clr = 1'b1;
        cycle();
        clr = 1'b0;
        check("clr_pop_swap", int'(swap_cnt), 0);
        check("clr_pop_count", int'(count), 0);

        // Saturation on the 2-bit counter instance.
        rst_n = 1'b0;
        cycle();
        rst_n = 1'b1;
        for (int i = 0; i < 5; i++) begin
            drive(1'b1, 8'(8'hB0 + i), 8'(8'h30 + i));
            dn_ready = 1'b1;
            cycle();
            in_valid = 1'b0;
            cycle();
        end
        check("sat_cnt", int'(swap_cnt2), 3);
        check("sat_wide_cnt", int'(swap_cnt), 5);
        cycle();

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
